// File: rtl/uart_img_pkg.sv
// Constants, state encoding and helpers shared by the image/message byte
// scheduler and the byte transmitter it feeds.
package uart_img_pkg;

  localparam logic [7:0] CMD               = 8'h01;
  localparam int         IMG_BYTES_DEFAULT = 240 * 320 * 2;
  localparam int         MSG_MAX           = 16;
  localparam int         MSG_LEN_W         = $clog2(MSG_MAX + 1);
  localparam int         MSG_IDX_W         = $clog2(MSG_MAX);

  localparam int BAUD                 = 115200;
  localparam int SYS_CLK_PERIOD       = 20;  // ns
  localparam int CLKS_PER_BIT_DEFAULT = 1_000_000_000 / (SYS_CLK_PERIOD * BAUD);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, IMG, TRL0, TRL1, MSG, GAP
  } sched_state_e;

  // Index of the final message byte; a zero length still sends one byte.
  function automatic logic [MSG_IDX_W-1:0] msg_last_idx(input logic [MSG_LEN_W-1:0] len);
    if (len == '0) return '0;
    if (len > MSG_LEN_W'(MSG_MAX)) return MSG_IDX_W'(MSG_MAX - 1);
    return MSG_IDX_W'(len - MSG_LEN_W'(1));
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Start/busy byte channel between the scheduler and the UART transmitter.
interface uart_tx_sched_if;
  logic [7:0] TX_DATA;
  logic       TX_START;
  logic       TX_BUSY;

  modport master (output TX_DATA, output TX_START, input TX_BUSY);
  modport slave  (input TX_DATA, input TX_START, output TX_BUSY);
endinterface

// File: rtl/uart_byte_tx.sv
// Plain 8N1 transmitter: latches TX_DATA on TX_START, busy until the stop
// bit has been on the line for a full bit time.
module uart_byte_tx
  import uart_img_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic            SYS_CLK,
  input  logic            RST_N,
  uart_tx_sched_if.slave  tx,
  output logic            TXD
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic             busy_q;
  logic [9:0]       shift_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       bit_q;

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q  <= 1'b0;
      shift_q <= '1;
      div_q   <= '0;
      bit_q   <= '0;
    end else if (!busy_q) begin
      if (tx.TX_START) begin
        busy_q  <= 1'b1;
        shift_q <= {1'b1, tx.TX_DATA, 1'b0};
        div_q   <= '0;
        bit_q   <= '0;
      end
    end else if (div_q == DIV_W'(CLKS_PER_BIT - 1)) begin
      div_q   <= '0;
      shift_q <= {1'b1, shift_q[9:1]};
      if (bit_q == 4'd9) busy_q <= 1'b0;
      else               bit_q  <= bit_q + 4'd1;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tx.TX_BUSY = busy_q;
  assign TXD        = busy_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/uart_tx_sched.sv
// Frames camera images (01 FE <payload> FE 01) and slots short messages in
// between frames, feeding one start/busy byte transmitter.
module uart_tx_sched
  import uart_img_pkg::*;
#(
  parameter int IMG_BYTES = IMG_BYTES_DEFAULT
) (
  input  logic                 SYS_CLK,
  input  logic                 RST_N,
  input  logic                 FRAME_REQ,
  input  logic                 FIFO_EMPTY,
  input  logic [7:0]           FIFO_DATA,
  output logic                 FIFO_RDREQ,
  input  logic                 MSG_REQ,
  input  logic [MSG_LEN_W-1:0] MSG_LEN,
  output logic [MSG_IDX_W-1:0] MSG_IDX,
  input  logic [7:0]           MSG_DATA,
  output logic                 MSG_ACK,
  uart_tx_sched_if.master      tx,
  output logic                 FRAME_DONE,
  output logic                 BUSY
);

  localparam int             CNT_W    = $clog2(IMG_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMG_BYTES - 1);

  sched_state_e         state_q, state_d;
  logic                 pending_q, pending_d;
  logic                 last_was_msg_q, last_was_msg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MSG_IDX_W-1:0] msg_last_q, msg_last_d;
  logic [MSG_IDX_W-1:0] msg_idx_q, msg_idx_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 rdreq_q, rdreq_d;
  logic                 ack_q, ack_d;
  logic                 done_q, done_d;
  logic                 can_issue;
  logic                 frame_want;

  // tx_start_q doubles as the one-cycle guard that covers the TX_BUSY rise latency.
  assign can_issue  = !tx.TX_BUSY && !tx_start_q;
  assign frame_want = pending_q || FRAME_REQ;

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q || FRAME_REQ;
    last_was_msg_d = last_was_msg_q;
    cnt_d          = cnt_q;
    msg_last_d     = msg_last_q;
    msg_idx_d      = msg_idx_q;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    rdreq_d        = 1'b0;
    ack_d          = 1'b0;
    done_d         = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Only contested grants flip priority, so back-to-back contests alternate.
        if (frame_want && (!MSG_REQ || last_was_msg_q)) begin
          state_d   = HDR0;
          pending_d = 1'b0;
          if (MSG_REQ) last_was_msg_d = 1'b0;
        end else if (MSG_REQ) begin
          state_d    = MSG;
          msg_last_d = msg_last_idx(MSG_LEN);
          msg_idx_d  = '0;
          if (frame_want) last_was_msg_d = 1'b1;
        end
      end
      HDR0: if (can_issue) begin
        tx_data_d = CMD;  tx_start_d = 1'b1;  state_d = HDR1;
      end
      HDR1: if (can_issue) begin
        tx_data_d = ~CMD; tx_start_d = 1'b1;  state_d = IMG;
      end
      IMG: if (can_issue && !FIFO_EMPTY) begin
        tx_data_d  = FIFO_DATA;
        tx_start_d = 1'b1;
        rdreq_d    = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = TRL0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TRL0: if (can_issue) begin
        tx_data_d = ~CMD; tx_start_d = 1'b1;  state_d = TRL1;
      end
      TRL1: if (can_issue) begin
        tx_data_d = CMD;  tx_start_d = 1'b1;  done_d = 1'b1;  state_d = GAP;
      end
      MSG: if (can_issue) begin
        tx_data_d  = MSG_DATA;
        tx_start_d = 1'b1;
        if (msg_idx_q == msg_last_q) begin
          ack_d     = 1'b1;
          msg_idx_d = '0;
          state_d   = GAP;
        end else begin
          msg_idx_d = msg_idx_q + MSG_IDX_W'(1);
        end
      end
      GAP: if (can_issue) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= IDLE;
      pending_q      <= 1'b0;
      last_was_msg_q <= 1'b0;
      cnt_q          <= '0;
      msg_last_q     <= '0;
      msg_idx_q      <= '0;
      tx_data_q      <= 8'hFF;
      tx_start_q     <= 1'b0;
      rdreq_q        <= 1'b0;
      ack_q          <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      last_was_msg_q <= last_was_msg_d;
      cnt_q          <= cnt_d;
      msg_last_q     <= msg_last_d;
      msg_idx_q      <= msg_idx_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
      rdreq_q        <= rdreq_d;
      ack_q          <= ack_d;
      done_q         <= done_d;
    end
  end

  assign tx.TX_DATA  = tx_data_q;
  assign tx.TX_START = tx_start_q;
  assign FIFO_RDREQ  = rdreq_q;
  assign MSG_IDX     = msg_idx_q;
  assign MSG_ACK     = ack_q;
  assign FRAME_DONE  = done_q;
  assign BUSY        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched driving a real byte transmitter; sent
// bytes are checked in order against a queue filled as stimulus is applied.
module tb_uart_tx_sched;
  import uart_img_pkg::*;

  localparam int IMG = 4;
  localparam int CPB = 2;

  logic                 SYS_CLK = 1'b0;
  logic                 RST_N = 1'b0;
  logic                 FRAME_REQ = 1'b0;
  logic                 MSG_REQ = 1'b0;
  logic [MSG_LEN_W-1:0] MSG_LEN = '0;
  logic [7:0]           MSG_DATA;
  logic [MSG_IDX_W-1:0] MSG_IDX;
  logic                 FIFO_EMPTY, FIFO_RDREQ, MSG_ACK, FRAME_DONE, BUSY, TXD;
  logic [7:0]           FIFO_DATA;

  logic [7:0] fifo_mem [0:31];
  int         fifo_wr = 0;
  int         fifo_rd = 0;
  logic [7:0] msg_mem [0:15];

  logic [7:0] exp_q [$];
  int errors = 0, checks = 0;
  int n_start = 0, n_rdreq = 0, n_ack = 0, n_done = 0;
  logic prev_start = 1'b0;

  uart_tx_sched_if tx_bus ();

  uart_tx_sched #(.IMG_BYTES(IMG)) dut (
    .SYS_CLK(SYS_CLK), .RST_N(RST_N), .FRAME_REQ(FRAME_REQ),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA), .FIFO_RDREQ(FIFO_RDREQ),
    .MSG_REQ(MSG_REQ), .MSG_LEN(MSG_LEN), .MSG_IDX(MSG_IDX), .MSG_DATA(MSG_DATA),
    .MSG_ACK(MSG_ACK), .tx(tx_bus), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
  );

  uart_byte_tx #(.CLKS_PER_BIT(CPB)) peer (
    .SYS_CLK(SYS_CLK), .RST_N(RST_N), .tx(tx_bus), .TXD(TXD)
  );

  always #10 SYS_CLK = ~SYS_CLK;

  assign FIFO_EMPTY = (fifo_wr == fifo_rd);
  assign FIFO_DATA  = fifo_mem[fifo_rd[4:0]];

  always @(posedge SYS_CLK) begin
    if (FIFO_RDREQ && !FIFO_EMPTY) fifo_rd <= fifo_rd + 1;
    MSG_DATA <= msg_mem[MSG_IDX];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    @(posedge SYS_CLK);
    #1;
    if (prev_start) chk("busy_rise", 32'(tx_bus.TX_BUSY), 32'd1);
    prev_start = tx_bus.TX_START && RST_N;
    if (tx_bus.TX_START) begin
      n_start++;
      $display("tx byte %02h", tx_bus.TX_DATA);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL tx_unexpected observed=%02h expected=none", tx_bus.TX_DATA);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_byte", 32'(tx_bus.TX_DATA), 32'(e));
      end
    end
    if (FIFO_RDREQ) n_rdreq++;
    if (FRAME_DONE) begin
      n_done++;
      chk("done_with_last", {23'd0, tx_bus.TX_START, tx_bus.TX_DATA}, {23'd0, 1'b1, CMD});
    end
    if (MSG_ACK) begin
      n_ack++;
      chk("ack_with_start", 32'(tx_bus.TX_START), 32'd1);
      MSG_REQ = 1'b0;
    end
  endtask

  task automatic exp_frame(input logic [31:0] p);
    exp_q.push_back(CMD);
    exp_q.push_back(~CMD);
    for (int i = 0; i < 4; i++) exp_q.push_back(p[31-8*i -: 8]);
    exp_q.push_back(~CMD);
    exp_q.push_back(CMD);
  endtask

  task automatic fifo_push(input logic [31:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[fifo_wr[4:0]] = p[31-8*i -: 8];
      fifo_wr++;
    end
  endtask

  task automatic run_until_idle(input string tag);
    int n = 0;
    tick();
    while ((BUSY !== 1'b0 || exp_q.size() != 0) && n < 5000) begin
      tick();
      n++;
    end
    chk(tag, {BUSY, 31'(exp_q.size())}, 32'd0);
  endtask

  task automatic wait_rdreq(input int target, input string tag);
    int n = 0;
    while (n_rdreq < target && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, 32'(n_rdreq), 32'(target));
  endtask

  task automatic pulse_frame_req();
    FRAME_REQ = 1'b1;
    tick();
    FRAME_REQ = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    int s, r, a, d;

    // Reset values
    tick();
    tick();
    chk("reset_outputs",
        {15'd0, BUSY, tx_bus.TX_START, FIFO_RDREQ, MSG_ACK, FRAME_DONE, tx_bus.TX_DATA, MSG_IDX},
        {15'd0, 5'b00000, 8'hFF, 4'h0});
    RST_N = 1'b1;
    tick();

    // Basic frame
    r = n_rdreq; d = n_done;
    fifo_push(32'h11223344, 4);
    exp_frame(32'h11223344);
    pulse_frame_req();
    chk("grant_busy", 32'(BUSY), 32'd1);
    tick();
    chk("first_start_latency", 32'(tx_bus.TX_START), 32'd1);
    run_until_idle("frame1_idle");
    chk("frame1_rdreq", 32'(n_rdreq - r), 32'd4);
    chk("frame1_done", 32'(n_done - d), 32'd1);

    // FIFO stall after two payload bytes
    r = n_rdreq;
    fifo_push(32'h55660000, 2);
    exp_frame(32'h55667788);
    pulse_frame_req();
    wait_rdreq(r + 2, "stall_first_two");
    repeat (50) tick();
    s = n_start;
    repeat (500) tick();
    chk("stall_no_start", 32'(n_start), 32'(s));
    chk("stall_busy", 32'(BUSY), 32'd1);
    fifo_push(32'h77880000, 2);
    run_until_idle("stall_resume_idle");

    // Plain message
    a = n_ack;
    msg_mem[0] = 8'hA0; msg_mem[1] = 8'hA1; msg_mem[2] = 8'hA2;
    MSG_LEN = MSG_LEN_W'(3);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    MSG_REQ = 1'b1;
    run_until_idle("msg_idle");
    chk("msg_ack_count", 32'(n_ack - a), 32'd1);
    chk("msg_idx_back_to_0", 32'(MSG_IDX), 32'd0);

    // Contested requests from reset: message first, then frame first
    do_reset();
    msg_mem[0] = 8'hB0; msg_mem[1] = 8'hB1;
    MSG_LEN = MSG_LEN_W'(2);
    fifo_push(32'hC1C2C3C4, 4);
    exp_q.push_back(8'hB0); exp_q.push_back(8'hB1);
    exp_frame(32'hC1C2C3C4);
    MSG_REQ = 1'b1;
    pulse_frame_req();
    run_until_idle("pair1_idle");
    msg_mem[0] = 8'hD0;
    MSG_LEN = '0;
    fifo_push(32'hC5C6C7C8, 4);
    exp_frame(32'hC5C6C7C8);
    exp_q.push_back(8'hD0);
    MSG_REQ = 1'b1;
    pulse_frame_req();
    run_until_idle("pair2_idle");
    chk("pair2_idx", 32'(MSG_IDX), 32'd0);

    // Message raised mid-frame waits for the trailer
    r = n_rdreq;
    fifo_push(32'h31323334, 4);
    exp_frame(32'h31323334);
    pulse_frame_req();
    wait_rdreq(r + 1, "midframe_payload");
    msg_mem[0] = 8'hE0; msg_mem[1] = 8'hE1; msg_mem[2] = 8'hE2;
    MSG_LEN = MSG_LEN_W'(3);
    exp_q.push_back(8'hE0); exp_q.push_back(8'hE1); exp_q.push_back(8'hE2);
    MSG_REQ = 1'b1;
    run_until_idle("midframe_idle");

    // Reset during payload byte 2 aborts the frame
    r = n_rdreq;
    fifo_push(32'hF1F2F3F4, 4);
    exp_frame(32'hF1F2F3F4);
    pulse_frame_req();
    wait_rdreq(r + 2, "abort_two_payload");
    tick();
    #3 RST_N = 1'b0;
    #1;
    chk("abort_outputs",
        {15'd0, BUSY, tx_bus.TX_START, FIFO_RDREQ, MSG_ACK, FRAME_DONE, tx_bus.TX_DATA, MSG_IDX},
        {15'd0, 5'b00000, 8'hFF, 4'h0});
    exp_q.delete();
    tick();
    tick();
    RST_N = 1'b1;
    s = n_start;
    repeat (200) tick();
    chk("abort_quiet", 32'(n_start), 32'(s));
    chk("abort_not_busy", 32'(BUSY), 32'd0);
    fifo_push(32'hF5F60000, 2);
    exp_frame(32'hF3F4F5F6);
    pulse_frame_req();
    run_until_idle("after_abort_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
